ycrcb_to_rgb: RTL

// - Converts 8-bit full-range YCrCb pixels back to 8-bit RGB (BT.601, inverse of the RGB->YCrCb front end).
// - Sits on the display/debug path after vision processing.
// - 3-stage pipeline with valid/ready streaming, global stall, and frame sideband (sof/eol) carried in alignment.

---
 rtl/ycrcb_to_rgb_if.sv | 46 ++++
 rtl/ycrcb_to_rgb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ycrcb_to_rgb_if.sv
// ----------------------------------------------------------------------------
// ycrcb_to_rgb_if
// Streaming bundle for the YCrCb -> RGB converter.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. A producer holds its data and sideband stable while valid is
// high and ready is low. Valid never depends on ready on the same side.
//
// Signals
//   in_valid  / in_ready      input pixel handshake
//   in_y, in_cr, in_cb        8-bit pixel components (Cr/Cb offset 128)
//   in_sof, in_eol            frame/line sideband for the input pixel
//   out_valid / out_ready     output pixel handshake
//   out_r, out_g, out_b       8-bit RGB result
//   out_sof, out_eol          sideband aligned with the output pixel
//
// Modports
//   slave  : the converter (consumes in_*, produces out_*)
//   master : the environment driving pixels and accepting results
// ----------------------------------------------------------------------------
interface ycrcb_to_rgb_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_y;
    logic [7:0] in_cr;
    logic [7:0] in_cb;
    logic       in_sof;
    logic       in_eol;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r;
    logic [7:0] out_g;
    logic [7:0] out_b;
    logic       out_sof;
    logic       out_eol;

    modport slave (
        input  in_valid, in_y, in_cr, in_cb, in_sof, in_eol, out_ready,
        output in_ready, out_valid, out_r, out_g, out_b, out_sof, out_eol
    );

    modport master (
        output in_valid, in_y, in_cr, in_cb, in_sof, in_eol, out_ready,
        input  in_ready, out_valid, out_r, out_g, out_b, out_sof, out_eol
    );
endinterface

// File: rtl/ycrcb_to_rgb.sv
// ----------------------------------------------------------------------------
// ycrcb_to_rgb
// Converts 8-bit full-range YCrCb pixels to 8-bit RGB (BT.601 inverse) in a
// 3-stage pipeline with valid/ready streaming and a single global stall.
//
//   S1: centre chroma (cr-128, cb-128 as signed 9-bit), register luma
//   S2: Q8 signed products of the chroma terms, luma scaled by 256
//   S3: sum, round (+128), arithmetic >>>8, clamp to 0..255
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (discards in-flight pixels)
//   bus      ycrcb_to_rgb_if.slave stream (in_* pixels, out_* results)
//   sat_clr  synchronous clear of the saturation counter   (optional)
//   sat_cnt  count of emitted pixels that clamped a channel (optional)
//
// Optional feature: define YCRCB_SAT_CNT_EN to add sat_clr/sat_cnt. The
// counter increments on each output handshake whose pixel clamped on any
// channel, saturates at all-ones, and a same-cycle sat_clr wins (result 0).
// Datapath and timing are identical either way.
//
// Flow control: adv = !out_valid || out_ready; in_ready = adv. Every stage
// loads on adv and holds otherwise, so bubbles travel as valid=0.
// ----------------------------------------------------------------------------
module ycrcb_to_rgb #(
    parameter int K_RCR = 359,
    parameter int K_GCB = 88,
    parameter int K_GCR = 183,
    parameter int K_BCB = 454,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    ycrcb_to_rgb_if.slave       bus
`ifdef YCRCB_SAT_CNT_EN
    ,
    input  logic                sat_clr,
    output logic [CNT_W-1:0]    sat_cnt
`endif
);

    localparam logic signed [17:0] C_RCR = 18'(K_RCR);
    localparam logic signed [17:0] C_GCB = 18'(K_GCB);
    localparam logic signed [17:0] C_GCR = 18'(K_GCR);
    localparam logic signed [17:0] C_BCB = 18'(K_BCB);

    // Round-shifted sum clamped to an unsigned byte.
    function automatic logic [7:0] clamp_u8(input logic signed [19:0] s);
        logic signed [19:0] sh;
        sh = s >>> 8;
        if (sh < 20'sd0)
            clamp_u8 = 8'd0;
        else if (sh > 20'sd255)
            clamp_u8 = 8'hFF;
        else
            clamp_u8 = sh[7:0];
    endfunction

`ifdef YCRCB_SAT_CNT_EN
    function automatic logic out_of_range(input logic signed [19:0] s);
        logic signed [19:0] sh;
        sh = s >>> 8;
        out_of_range = (sh < 20'sd0) || (sh > 20'sd255);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_adv;
    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    // ------------------------------------------------------------------
    // Stage 1: centre chroma
    // ------------------------------------------------------------------
    logic              r1_valid, r1_sof, r1_eol;
    logic [7:0]        r1_y;
    logic signed [8:0] r1_cr, r1_cb;
    logic signed [8:0] w_cr_c, w_cb_c;

    assign w_cr_c = signed'({1'b0, bus.in_cr}) - 9'sd128;
    assign w_cb_c = signed'({1'b0, bus.in_cb}) - 9'sd128;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sof   <= 1'b0;
            r1_eol   <= 1'b0;
            r1_y     <= 8'd0;
            r1_cr    <= 9'sd0;
            r1_cb    <= 9'sd0;
        end else if (w_adv) begin
            r1_valid <= bus.in_valid;
            r1_sof   <= bus.in_sof;
            r1_eol   <= bus.in_eol;
            r1_y     <= bus.in_y;
            r1_cr    <= w_cr_c;
            r1_cb    <= w_cb_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: Q8 products
    // ------------------------------------------------------------------
    logic               r2_valid, r2_sof, r2_eol;
    logic [15:0]        r2_y8;
    logic signed [17:0] r2_p_rcr, r2_p_gcb, r2_p_gcr, r2_p_bcb;
    logic signed [17:0] w_cr_ext, w_cb_ext;

    assign w_cr_ext = {{9{r1_cr[8]}}, r1_cr};
    assign w_cb_ext = {{9{r1_cb[8]}}, r1_cb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_sof   <= 1'b0;
            r2_eol   <= 1'b0;
            r2_y8    <= 16'd0;
            r2_p_rcr <= 18'sd0;
            r2_p_gcb <= 18'sd0;
            r2_p_gcr <= 18'sd0;
            r2_p_bcb <= 18'sd0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_sof   <= r1_sof;
            r2_eol   <= r1_eol;
            r2_y8    <= {r1_y, 8'h00};
            r2_p_rcr <= C_RCR * w_cr_ext;
            r2_p_gcb <= C_GCB * w_cb_ext;
            r2_p_gcr <= C_GCR * w_cr_ext;
            r2_p_bcb <= C_BCB * w_cb_ext;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: sum, round, clamp
    // ------------------------------------------------------------------
    logic signed [19:0] w_y8, w_sum_r, w_sum_g, w_sum_b;

    // 20 bits covers the worst case (255*256 + 454*127 + 128 = 123066).
    assign w_y8    = signed'({4'b0000, r2_y8});
    assign w_sum_r = w_y8 + {{2{r2_p_rcr[17]}}, r2_p_rcr} + 20'sd128;
    assign w_sum_g = w_y8 - {{2{r2_p_gcb[17]}}, r2_p_gcb}
                          - {{2{r2_p_gcr[17]}}, r2_p_gcr} + 20'sd128;
    assign w_sum_b = w_y8 + {{2{r2_p_bcb[17]}}, r2_p_bcb} + 20'sd128;

    logic       r3_valid, r3_sof, r3_eol;
    logic [7:0] r3_r, r3_g, r3_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r3_sof   <= 1'b0;
            r3_eol   <= 1'b0;
            r3_r     <= 8'd0;
            r3_g     <= 8'd0;
            r3_b     <= 8'd0;
        end else if (w_adv) begin
            r3_valid <= r2_valid;
            r3_sof   <= r2_sof;
            r3_eol   <= r2_eol;
            r3_r     <= clamp_u8(w_sum_r);
            r3_g     <= clamp_u8(w_sum_g);
            r3_b     <= clamp_u8(w_sum_b);
        end
    end

    assign bus.out_valid = r3_valid;
    assign bus.out_sof   = r3_sof;
    assign bus.out_eol   = r3_eol;
    assign bus.out_r     = r3_r;
    assign bus.out_g     = r3_g;
    assign bus.out_b     = r3_b;

`ifdef YCRCB_SAT_CNT_EN
    // ------------------------------------------------------------------
    // Saturation counter: the clamp flag rides along in S3 with its pixel
    // so the count is taken on the output handshake, not on entry.
    // ------------------------------------------------------------------
    logic             r3_sat;
    logic [CNT_W-1:0] r_sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r3_sat <= 1'b0;
        else if (w_adv)
            r3_sat <= out_of_range(w_sum_r) || out_of_range(w_sum_g) ||
                      out_of_range(w_sum_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_cnt <= '0;
        else if (sat_clr)
            r_sat_cnt <= '0;
        else if (r3_valid && bus.out_ready && r3_sat && (r_sat_cnt != '1))
            r_sat_cnt <= r_sat_cnt + 1'b1;
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule
